// File: rtl/mash_pkg.sv
// Shared constants and the MASH 1-1-1 noise-cancellation recombiner.
// Every module of the receive-side reconstruction path imports these.
package mash_pkg;

    localparam int C_MOD_WIDTH = 4;
    localparam int C_NC_DEPTH  = 2;
    localparam int C_MOD_MIN   = -3;
    localparam int C_MOD_MAX   = 4;

    typedef logic [C_MOD_WIDTH-1:0] mod_t;

    // History vectors: bit 0 is sample n-1, bit 1 is sample n-2.
    // y = q1[n-2] + q2[n-1] - q2[n-2] + q3[n] - 2*q3[n-1] + q3[n-2]
    function automatic mod_t mash_recombine(
        input logic [C_NC_DEPTH-1:0] q1_hist,
        input logic [C_NC_DEPTH-1:0] q2_hist,
        input logic [C_NC_DEPTH-1:0] q3_hist,
        input logic                  q3_now
    );
        mod_t y;
        y = mod_t'(q1_hist[1])
          + mod_t'(q2_hist[0]) - mod_t'(q2_hist[1])
          + mod_t'(q3_now) - mod_t'({q3_hist[0], 1'b0}) + mod_t'(q3_hist[1]);
        return y;
    endfunction

endpackage

// File: rtl/mash_avg_window.sv
// Windowed accumulator: sums exactly 2^P_AVG_LOG2 valid signed samples and
// publishes the total with a one-cycle valid pulse.
module mash_avg_window #(
    parameter int P_AVG_LOG2 = 6,
    parameter int P_IN_W     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [P_IN_W-1:0]       i_data,
    output logic [P_AVG_LOG2+3:0]   o_avg_data,
    output logic                    o_avg_valid
);

    localparam int C_ACC_W = P_AVG_LOG2 + 4;

    logic [P_AVG_LOG2-1:0] r_cnt;
    logic [C_ACC_W-1:0]    r_acc;
    logic [C_ACC_W-1:0]    r_avg_data;
    logic                  r_avg_valid;
    logic [C_ACC_W-1:0]    w_ext;
    logic [C_ACC_W-1:0]    w_sum;

    always_comb begin
        w_ext = {{(C_ACC_W-P_IN_W){i_data[P_IN_W-1]}}, i_data};
        w_sum = r_acc + w_ext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_avg_data  <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (i_valid) begin
                if (r_cnt == '1) begin
                    r_avg_data  <= w_sum;
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_avg_data  = r_avg_data;
    assign o_avg_valid = r_avg_valid;

endmodule

// File: rtl/mash_noise_cancel.sv
// MASH 1-1-1 receive-side recombiner: noise-cancellation network on the
// three quantizer bit streams followed by a windowed mean recovery.
module mash_noise_cancel
    import mash_pkg::*;
#(
    parameter int P_AVG_LOG2 = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_quantize1,
    input  logic                  i_quantize2,
    input  logic                  i_quantize3,
    output logic [3:0]            o_mod_data,
    output logic                  o_mod_valid,
    output logic [P_AVG_LOG2+3:0] o_avg_data,
    output logic                  o_avg_valid
);

    logic [C_NC_DEPTH-1:0]  r_q1_hist;
    logic [C_NC_DEPTH-1:0]  r_q2_hist;
    logic [C_NC_DEPTH-1:0]  r_q3_hist;
    logic [1:0]             r_fill;
    logic [C_MOD_WIDTH-1:0] r_mod_data;
    logic                   r_mod_valid;
    logic [C_MOD_WIDTH-1:0] w_y;

    always_comb begin
        w_y = mash_recombine(r_q1_hist, r_q2_hist, r_q3_hist, i_quantize3);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1_hist   <= '0;
            r_q2_hist   <= '0;
            r_q3_hist   <= '0;
            r_fill      <= '0;
            r_mod_data  <= '0;
            r_mod_valid <= 1'b0;
        end else if (i_en) begin
            r_q1_hist   <= {r_q1_hist[0], i_quantize1};
            r_q2_hist   <= {r_q2_hist[0], i_quantize2};
            r_q3_hist   <= {r_q3_hist[0], i_quantize3};
            r_fill      <= (r_fill == 2'd3) ? r_fill : r_fill + 2'd1;
            r_mod_data  <= w_y;
            // Fill count 2 or 3 means both history taps already hold real samples.
            r_mod_valid <= r_fill[1];
        end else begin
            r_mod_valid <= 1'b0;
        end
    end

    assign o_mod_data  = r_mod_data;
    assign o_mod_valid = r_mod_valid;

    mash_avg_window #(
        .P_AVG_LOG2 (P_AVG_LOG2),
        .P_IN_W     (C_MOD_WIDTH)
    ) u_avg_window (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (r_mod_valid),
        .i_data      (r_mod_data),
        .o_avg_data  (o_avg_data),
        .o_avg_valid (o_avg_valid)
    );

    a_mod_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_mod_valid |-> ($signed(r_mod_data) >= C_MOD_MIN && $signed(r_mod_data) <= C_MOD_MAX));

endmodule

// File: tb/tb_mash_noise_cancel.sv
// Scoreboard bench for mash_noise_cancel: directed sample vectors push their
// hand-derived responses; a negedge monitor pops and compares.
module tb_mash_noise_cancel;

    localparam int L = 6;
    localparam int N = 1 << L;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_en = 1'b0;
    logic         i_quantize1 = 1'b0;
    logic         i_quantize2 = 1'b0;
    logic         i_quantize3 = 1'b0;
    logic [3:0]   o_mod_data;
    logic         o_mod_valid;
    logic [L+3:0] o_avg_data;
    logic         o_avg_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int mod_q[$];
    int avg_q[$];
    int b_fill = 0;
    int b_win  = 0;
    int b_acc  = 0;
    int last_exp = 0;

    mash_noise_cancel #(.P_AVG_LOG2(L)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_quantize1 (i_quantize1),
        .i_quantize2 (i_quantize2),
        .i_quantize3 (i_quantize3),
        .o_mod_data  (o_mod_data),
        .o_mod_valid (o_mod_valid),
        .o_avg_data  (o_avg_data),
        .o_avg_valid (o_avg_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented sample or window result must match the queue head.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_mod_valid) begin
                if (mod_q.size() == 0) check("mod_unexpected_valid", 1, 0);
                else check("mod_data", int'($signed(o_mod_data)), mod_q.pop_front());
            end
            if (o_avg_valid) begin
                if (avg_q.size() == 0) check("avg_unexpected_valid", 1, 0);
                else check("avg_data", int'($signed(o_avg_data)), avg_q.pop_front());
            end
        end
    end

    // One consumed sample; exp is the hand-derived recombined value.
    task automatic sample(input bit q1, input bit q2, input bit q3, input int exp);
        i_en = 1'b1;
        i_quantize1 = q1;
        i_quantize2 = q2;
        i_quantize3 = q3;
        last_exp = exp;
        if (b_fill >= 2) begin
            mod_q.push_back(exp);
            b_acc += exp;
            b_win++;
            if (b_win == N) begin
                avg_q.push_back(b_acc);
                b_acc = 0;
                b_win = 0;
            end
        end
        if (b_fill < 3) b_fill++;
        @(posedge i_clk);
        #1;
        i_en = 1'b0;
    endtask

    // Idle cycle with junk on the quantizer inputs: nothing may be consumed.
    task automatic idle();
        i_en = 1'b0;
        i_quantize1 = 1'($urandom_range(0, 1));
        i_quantize2 = 1'($urandom_range(0, 1));
        i_quantize3 = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
        check("gap_valid_low", int'(o_mod_valid), 0);
        check("gap_data_hold", int'($signed(o_mod_data)), last_exp);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mod_data", int'(o_mod_data), 0);
        check("rst_mod_valid", int'(o_mod_valid), 0);
        check("rst_avg_data", int'(o_avg_data), 0);
        check("rst_avg_valid", int'(o_avg_valid), 0);
        mod_q.delete();
        avg_q.delete();
        b_fill = 0;
        b_win = 0;
        b_acc = 0;
        last_exp = 0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // q1 held at 1 with a q3 pulse at index%16==5: 1 + (+1,-2,+1).
    function automatic int exp_pat(input int i);
        if (i < 2) return 0;
        case (i % 16)
            5: return 2;
            6: return -1;
            7: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic pat_sample(input int i, input bit gaps);
        int g;
        g = 0;
        while (gaps && $urandom_range(0, 1) == 1 && g < 8) begin
            idle();
            g++;
        end
        sample(1'b1, 1'b0, (i % 16) == 5, exp_pat(i));
    endtask

    initial begin
        @(posedge i_clk);
        #1;
        do_reset();

        // All-zero inputs: data 0, window results 0.
        for (int i = 0; i < 200; i++) sample(1'b0, 1'b0, 1'b0, 0);

        // Constant q1: y = 1 once q1[n-2] is filled; first window sums to N.
        do_reset();
        for (int i = 0; i < 70; i++) sample(1'b1, 1'b0, 1'b0, (i < 2) ? 0 : 1);

        // Single q3 pulse then single q2 pulse.
        do_reset();
        for (int i = 0; i < 4; i++) sample(1'b0, 1'b0, 1'b0, 0);
        sample(1'b0, 1'b0, 1'b1, 1);
        sample(1'b0, 1'b0, 1'b0, -2);
        sample(1'b0, 1'b0, 1'b0, 1);
        sample(1'b0, 1'b0, 1'b0, 0);
        sample(1'b0, 1'b1, 1'b0, 0);
        sample(1'b0, 1'b0, 1'b0, 1);
        sample(1'b0, 1'b0, 1'b0, -1);
        sample(1'b0, 1'b0, 1'b0, 0);
        sample(1'b0, 1'b0, 1'b0, 0);

        // Range extremes +4 then -3.
        sample(1'b1, 1'b0, 1'b1, 1);
        sample(1'b0, 1'b1, 1'b0, -2);
        sample(1'b0, 1'b0, 1'b1, 4);
        sample(1'b0, 1'b0, 1'b0, -3);
        sample(1'b0, 1'b0, 1'b0, 1);
        sample(1'b0, 1'b0, 1'b0, 0);

        // Random enable gaps, reset mid-window, then full windows with gaps.
        do_reset();
        for (int i = 0; i < 20; i++) pat_sample(i, 1'b1);
        do_reset();
        for (int i = 0; i < 140; i++) pat_sample(i, 1'b1);

        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
        end
        check("mod_queue_drained", mod_q.size(), 0);
        check("avg_queue_drained", avg_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mash_noise_cancel.md
# mash_noise_cancel

Receive-side recombiner for the noise-coupled MASH modulator. Takes the three 1-bit quantizer streams (stage 1, 2, 3) and applies the MASH 1-1-1 noise-cancellation network, y = q1·z⁻² + q2·(1−z⁻¹)·z⁻¹ + q3·(1−z⁻¹)². The result is a signed multi-level stream. A windowed accumulator then recovers the encoded mean value. Used as the loop-back checker and digital reconstruction path behind the modulator in the DDSM datapath.

## Interface
Parameters:
- P_AVG_LOG2, default 6: log2 of the averaging window length N = 2^P_AVG_LOG2 samples; legal range 1..16.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset; asynchronous, active-low.
- i_en, input, 1: sample enable; when 1, the three quantizer bits are consumed on this edge.
- i_quantize1, input, 1: stage-1 quantizer bit, value 0 or 1.
- i_quantize2, input, 1: stage-2 quantizer bit.
- i_quantize3, input, 1: stage-3 quantizer bit.
- o_mod_data, output, 4: recombined sample, two's complement, range −3..+4.
- o_mod_valid, output, 1: o_mod_data holds a sample computed from a full history.
- o_avg_data, output, P_AVG_LOG2+4: signed sum of the last N valid o_mod_data samples.
- o_avg_valid, output, 1: one-cycle pulse marking a new o_avg_data value.

## Operation
- History registers:
  - q1: 2-deep delay line.
  - q2: 2-deep delay line.
  - q3: 2-deep delay line, plus the current input.
  - All shift only on edges where i_en=1. When i_en=0 they hold.
- Recombination on a consumed edge, with sample index n = current input:
  - y = q1[n−2] + q2[n−1] − q2[n−2] + q3[n] − 2·q3[n−1] + q3[n−2].
  - Computed in at least 4-bit signed arithmetic. No saturation is needed: the range is −3..+4 exactly.
- Fill counter (2 bits, saturating at 3): increments on each consumed sample.
- o_mod_valid = 1 for a consumed sample only when the fill counter already equals 2 or 3, i.e. from the 3rd consumed sample onward.
- Window accumulator:
  - On each cycle with o_mod_valid=1, add sign-extended o_mod_data to the accumulator and increment the window counter.
  - When the counter reaches N−1 and a valid sample is added, do all of the following together:
    - move accumulator + sample to o_avg_data;
    - pulse o_avg_valid;
    - reset the accumulator to 0;
    - wrap the counter to 0.
- Meaning of o_avg_data: for a stationary input, o_avg_data / N equals the modulator's mean output. A constant fractional input f therefore gives o_avg_data ≈ f·N.
- Reset values (asynchronous on i_rst_n=0, all outputs):
  - o_mod_data=0, o_mod_valid=0, o_avg_data=0, o_avg_valid=0.
  - All history registers, the fill counter, the accumulator and the window counter are cleared to 0.
- Reset asserted mid-window: the partial sum is discarded. After release the fill sequence and the window restart from scratch.

## Timing
- o_mod_data and o_mod_valid are registered, with 1-cycle latency. Inputs consumed at edge t appear after edge t (usable in cycle t+1).
- i_en=0 at edge t: o_mod_valid=0 in cycle t+1, and o_mod_data holds its previous value.
- o_avg_valid rises exactly one cycle after the o_mod_valid that completes the window, and lasts 1 cycle.
  - o_avg_data is registered and holds until the next window completes.
- Gaps in i_en stretch the window in time but not in sample count. The window always contains exactly N valid samples.
- The first o_avg_valid after reset comes after N+2 consumed samples: 2 fill samples plus N window samples.

## Structure
- Shared package mash_pkg:
  - C_MOD_WIDTH = 4;
  - C_NC_DEPTH = 2 (history depth);
  - signed range constants C_MOD_MIN = −3 and C_MOD_MAX = 4, for the assertions.
- Sub-module mash_avg_window, containing the window counter, accumulator and output register. It is parameterised by P_AVG_LOG2 and the input width, and has a valid-in / data-in port pair.
- Top level contains:
  - the history registers;
  - the fill counter;
  - the recombination adder;
  - the output register.

## Test plan
- Reset, then i_en=1 with all inputs 0 for 200 cycles → o_mod_data=0 throughout, o_mod_valid from the 3rd sample, o_avg_data=0 with a pulse every 64 valid samples.
- q1=1 constant, q2=q3=0 → o_mod_data=1 once valid. First o_avg_valid (P_AVG_LOG2=6) gives o_avg_data=64.
- Single q3 pulse (1 at sample k, else 0), q1=q2=0, after the history fills → o_mod_data sequence +1, −2, +1 at samples k, k+1, k+2, then 0.
- Single q2 pulse at sample k → o_mod_data +1 at k+1, −1 at k+2, then 0.
- Range extremes:
  - history q1=1, q2: 0→1, q3: 1,0,1 → o_mod_data=+4;
  - q1=0, q2: 1→0, q3: 0,1,0 → −3.
- Toggle i_en with a random 50% duty cycle and assert i_rst_n low mid-window:
  - history holds across gaps;
  - each window counts exactly N valid samples;
  - the reset clears all outputs immediately and the fill/window restart.
